// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: instruction type encodings, opcodes,
// field bit positions and the decode helper used by the issue stage.
package mips_pkg;

    typedef enum logic [1:0] {
        TYPE_R    = 2'd0,
        TYPE_J    = 2'd1,
        TYPE_HALT = 2'd2,
        TYPE_I    = 2'd3
    } instr_type_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } issue_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        instr_type_t itype;
        logic        use_rs;
        logic        use_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } decoded_t;

    // Classify an instruction word and extract which registers it reads
    // and writes. A destination of 0 means the instruction writes nothing.
    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t   d;
        logic [5:0] op;
        op       = instr[OPCODE_HI:OPCODE_LO];
        d.rs     = instr[RS_HI:RS_LO];
        d.rt     = instr[RT_HI:RT_LO];
        d.itype  = TYPE_I;
        d.use_rs = 1'b0;
        d.use_rt = 1'b0;
        d.dest   = 5'd0;
        case (op)
            OP_RTYPE: begin
                d.itype  = TYPE_R;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.dest   = instr[RD_HI:RD_LO];
            end
            OP_J: begin
                d.itype = TYPE_J;
            end
            OP_JAL: begin
                d.itype = TYPE_J;
                d.dest  = LINK_REG;
            end
            OP_HALT: begin
                d.itype = TYPE_HALT;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            default: begin
                d.use_rs = 1'b1;
                d.dest   = instr[RT_HI:RT_LO];
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Fetch-to-issue, issue-to-EX and writeback signals of the decode stage.
interface id_issue_ctrl_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_type;
    logic [4:0]  out_dest;
    logic        wb_en;
    logic [4:0]  wb_addr;

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr,
        input  in_ready, out_valid, out_instr, out_type, out_dest
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr,
        output in_ready, out_valid, out_instr, out_type, out_dest
    );
endinterface

// File: rtl/reg_scoreboard.sv
// 32-entry pending-write scoreboard. Register 0 is never tracked; a set
// and a clear of the same register in one cycle leaves it pending.
module reg_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] chk_a_addr,
    output logic       chk_a_busy,
    input  logic [4:0] chk_b_addr,
    output logic       chk_b_busy,
    output logic       all_clear
);
    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // One-hot masks for the register being issued and the one retiring.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    // Apply clear first, then set, so a new writer stays in flight; bit 0 is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    assign chk_a_busy = pending[chk_a_addr];
    assign chk_b_busy = pending[chk_b_addr];
    assign all_clear  = (pending == 32'd0);
endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: decodes the fetched word, blocks on
// read-after-write hazards, holds one issued instruction for EX and
// drains the pipeline into a stopped state on HALT.
module id_issue_ctrl
    import mips_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_issue_ctrl_if.slave     bus,
    output logic               halted,
    output logic [STALL_W-1:0] stall_cycles
);
    issue_state_t state;
    decoded_t     dec;
    logic         rs_busy;
    logic         rt_busy;
    logic         all_clear;
    logic         hazard;
    logic         accept;
    logic         load;
    logic         take_halt;
    logic         set_en;

    assign dec = decode(bus.in_instr);

    assign hazard = (dec.use_rs && (dec.rs != 5'd0) && rs_busy) ||
                    (dec.use_rt && (dec.rt != 5'd0) && rt_busy);

    assign bus.in_ready = !rst && (state == ST_RUN) && !hazard &&
                          (!bus.out_valid || bus.out_ready);

    assign accept    = bus.in_valid && bus.in_ready;
    assign load      = accept && (dec.itype != TYPE_HALT);
    assign take_halt = accept && (dec.itype == TYPE_HALT);
    assign set_en    = load && (dec.dest != 5'd0);

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (set_en),
        .set_addr   (dec.dest),
        .clr_en     (bus.wb_en),
        .clr_addr   (bus.wb_addr),
        .chk_a_addr (dec.rs),
        .chk_a_busy (rs_busy),
        .chk_b_addr (dec.rt),
        .chk_b_busy (rt_busy),
        .all_clear  (all_clear)
    );

    // Run/drain/halted sequencing; halted is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_halt) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!bus.out_valid && all_clear) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Issue register: loads on accept, drops valid on consume, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_type  <= '0;
            bus.out_dest  <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= bus.in_instr;
            bus.out_type  <= dec.itype;
            bus.out_dest  <= dec.dest;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles fetch was held off by a hazard while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == ST_RUN) && bus.in_valid && hazard &&
                     (stall_cycles != {STALL_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: streaming, RAW stalls, jal link
// register, set/clear collision, backpressure, HALT drain and async reset.
module tb_id_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic [15:0] stall_cycles;
    int          total = 0;
    int          bad   = 0;

    id_issue_ctrl_if bus ();

    id_issue_ctrl #(.STALL_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic writeback(input logic [4:0] a);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        step();
        bus.wb_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        bus.out_ready = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_instr !== 32'd0) begin bad++; $display("FAIL rst_out_instr got=%h want=0", bus.out_instr); end
        total++; if (bus.out_dest !== 5'd0) begin bad++; $display("FAIL rst_out_dest got=%0d want=0", bus.out_dest); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0b want=0", halted); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cycles); end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1;
        bus.in_instr = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_r(5'd4, 5'd4, 5'd5, 6'h20);
        #1;
        total++; if (bus.out_dest !== 5'd3) begin bad++; $display("FAIL b2b_dest3 got=%0d want=3", bus.out_dest); end
        total++; if (bus.out_instr !== mk_r(5'd1, 5'd2, 5'd3, 6'h20)) begin bad++; $display("FAIL b2b_instr got=%h", bus.out_instr); end
        total++; if (bus.out_type !== 2'd0) begin bad++; $display("FAIL b2b_type got=%0d want=0", bus.out_type); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_second_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd5) begin bad++; $display("FAIL b2b_dest5 got=%0d want=5", bus.out_dest); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", bus.out_valid); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stall_cycles); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_consumed got=%0b want=0", bus.out_valid); end
        writeback(5'd3);
        writeback(5'd5);
    endtask

    task automatic test_raw_stall();
        bus.in_valid = 1'b1;
        bus.in_instr = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL raw_add_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_r(5'd3, 5'd1, 5'd6, 6'h22);
        for (int i = 1; i <= 4; i++) begin
            bus.wb_en   = (i == 4);
            bus.wb_addr = 5'd3;
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall_%0d got=%0b want=0", i, bus.in_ready); end
            step();
        end
        bus.wb_en = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL raw_unblock got=%0b want=1", bus.in_ready); end
        total++; if (stall_cycles !== 16'd4) begin bad++; $display("FAIL raw_stall_count got=%0d want=4", stall_cycles); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd6) begin bad++; $display("FAIL raw_sub_dest got=%0d want=6", bus.out_dest); end
        writeback(5'd6);
    endtask

    task automatic test_lw_sw();
        bus.in_valid = 1'b1;
        bus.in_instr = mk_i(6'b100011, 5'd1, 5'd7, 16'h0010);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lw_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_i(6'b101011, 5'd2, 5'd7, 16'h0004);
        #1;
        total++; if (bus.out_dest !== 5'd7) begin bad++; $display("FAIL lw_dest got=%0d want=7", bus.out_dest); end
        total++; if (bus.out_type !== 2'd3) begin bad++; $display("FAIL lw_type got=%0d want=3", bus.out_type); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL sw_stall1 got=%0b want=0", bus.in_ready); end
        step();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL sw_no_bypass got=%0b want=0", bus.in_ready); end
        step();
        bus.wb_en = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sw_unblock got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd0) begin bad++; $display("FAIL sw_dest got=%0d want=0", bus.out_dest); end
        total++; if (stall_cycles !== 16'd6) begin bad++; $display("FAIL sw_stall_count got=%0d want=6", stall_cycles); end
    endtask

    task automatic test_jal();
        bus.in_valid = 1'b1;
        bus.in_instr = {6'b000011, 26'h0012345};
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL jal_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_r(5'd31, 5'd0, 5'd8, 6'h20);
        #1;
        total++; if (bus.out_dest !== 5'd31) begin bad++; $display("FAIL jal_dest got=%0d want=31", bus.out_dest); end
        total++; if (bus.out_type !== 2'd1) begin bad++; $display("FAIL jal_type got=%0d want=1", bus.out_type); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL jal_r31_stall got=%0b want=0", bus.in_ready); end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd31;
        step();
        bus.wb_en = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL jal_unblock got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd8) begin bad++; $display("FAIL jal_add_dest got=%0d want=8", bus.out_dest); end
        total++; if (stall_cycles !== 16'd7) begin bad++; $display("FAIL jal_stall_count got=%0d want=7", stall_cycles); end
        writeback(5'd8);
    endtask

    task automatic test_set_clear_collision();
        bus.in_valid = 1'b1;
        bus.in_instr = mk_r(5'd1, 5'd2, 5'd9, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL coll_first got=%0b want=1", bus.in_ready); end
        step();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL coll_reissue got=%0b want=1", bus.in_ready); end
        step();
        bus.wb_en    = 1'b0;
        bus.in_instr = mk_r(5'd9, 5'd0, 5'd10, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL coll_pending9 got=%0b want=0", bus.in_ready); end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        step();
        bus.wb_en = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL coll_unblock got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd10) begin bad++; $display("FAIL coll_dest got=%0d want=10", bus.out_dest); end
        total++; if (stall_cycles !== 16'd8) begin bad++; $display("FAIL coll_stall_count got=%0d want=8", stall_cycles); end
        writeback(5'd10);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk_r(5'd1, 5'd2, 5'd11, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_r(5'd1, 5'd2, 5'd12, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked got=%0b want=0", bus.in_ready); end
        step();
        total++; if (bus.out_dest !== 5'd11) begin bad++; $display("FAIL bp_hold_dest got=%0d want=11", bus.out_dest); end
        total++; if (bus.out_instr !== mk_r(5'd1, 5'd2, 5'd11, 6'h20)) begin bad++; $display("FAIL bp_hold_instr got=%h", bus.out_instr); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b want=1", bus.out_valid); end
        total++; if (stall_cycles !== 16'd8) begin bad++; $display("FAIL bp_no_stall got=%0d want=8", stall_cycles); end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd12) begin bad++; $display("FAIL bp_next_dest got=%0d want=12", bus.out_dest); end
        writeback(5'd11);
        writeback(5'd12);
    endtask

    task automatic test_halt();
        bus.in_valid = 1'b1;
        bus.in_instr = mk_r(5'd1, 5'd2, 5'd13, 6'h20);
        step();
        bus.in_instr = 32'hFC00_0000;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL halt_accept got=%0b want=1", bus.in_ready); end
        step();
        bus.in_instr = mk_r(5'd13, 5'd0, 5'd14, 6'h20);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL halt_drain_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL halt_not_loaded got=%0b want=0", bus.out_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early1 got=%0b want=0", halted); end
        step();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_wait_wb got=%0b want=0", halted); end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd13;
        step();
        bus.wb_en = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early2 got=%0b want=0", halted); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_reached got=%0b want=1", halted); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL halted_ready got=%0b want=0", bus.in_ready); end
        total++; if (stall_cycles !== 16'd8) begin bad++; $display("FAIL halt_stall_count got=%0d want=8", stall_cycles); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%0b want=1", halted); end
    endtask

    task automatic test_reset_mid();
        total++; if (bus.out_dest !== 5'd13) begin bad++; $display("FAIL pre_reset_dest got=%0d want=13", bus.out_dest); end
        rst = 1'b1;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_rst_halted got=%0b want=0", halted); end
        total++; if (bus.out_dest !== 5'd0) begin bad++; $display("FAIL mid_rst_dest got=%0d want=0", bus.out_dest); end
        total++; if (bus.out_instr !== 32'd0) begin bad++; $display("FAIL mid_rst_instr got=%h want=0", bus.out_instr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b want=0", bus.out_valid); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL mid_rst_stall got=%0d want=0", stall_cycles); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b want=0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b want=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_dest !== 5'd14) begin bad++; $display("FAIL post_rst_dest got=%0d want=14", bus.out_dest); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL post_rst_halted got=%0b want=0", halted); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_lw_sw();
        test_jal();
        test_set_clear_collision();
        test_backpressure();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Issue controller for the decode stage of the 32-bit MIPS pipeline. It sits between the fetch output and the EX stage. It decodes each instruction's type and its source/destination registers, and tracks in-flight register writes in a 32-entry scoreboard. It stalls fetch on read-after-write hazards and sequences a HALT into a drained, stopped state.

## Interface
Parameters:
- `STALL_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_instr`  in  32  instruction word.
- `in_ready`  out  1  instruction accepted this cycle when `in_valid && in_ready`.
- `out_valid`  out  1  issue register holds an instruction for EX.
- `out_ready`  in  1  EX consumes the instruction when `out_valid && out_ready`.
- `out_instr`  out  32  issued instruction word.
- `out_type`  out  2  instruction type: R=0, J=1, HALT=2, I=3.
- `out_dest`  out  5  destination register; 0 means no write.
- `wb_en`  in  1  writeback retires a register write.
- `wb_addr`  in  5  register being written back.
- `halted`  out  1  the core has stopped.
- `stall_cycles`  out  `STALL_W`  count of hazard-stall cycles.

## Operation
- Type decode from `opcode = instr[31:26]`:
  - 000000 → R
  - 000010 or 000011 → J
  - 111111 → HALT
  - anything else → I
- Sources:
  - R: rs=[25:21], rt=[20:16].
  - I: rs, plus rt for sw (101011), beq (000100) and bne (000101).
  - J and HALT: none.
- Destination:
  - R: rd=[15:11].
  - I: rt, except sw/beq/bne, which have no destination.
  - jal (000011): 31.
  - j and HALT: 0.
- Scoreboard: 32 pending bits, all 0 after reset. Bit 0 is never set.
- `hazard` = any used source register ≠ 0 whose pending bit is 1.
  - Evaluated against registered scoreboard state only; there is no same-cycle bypass from `wb_en`.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN: `in_ready = !hazard && (!out_valid || out_ready)`.
    - Accepting a non-HALT instruction loads the issue register and sets `pending[dest]` when dest ≠ 0.
    - Accepting a HALT leaves the issue register unloaded and moves to DRAIN.
  - DRAIN: `in_ready = 0`. Moves to HALTED when `out_valid == 0` and all pending bits are 0.
  - HALTED: `in_ready = 0` and `halted = 1`. Left only by `rst`.
- Writeback: `wb_en` clears `pending[wb_addr]`.
  - Clearing an already-clear bit or bit 0 has no effect.
  - If a set and a clear hit the same register in the same cycle, the set wins (the new writer is still in flight).
- Issue register:
  - `out_valid` clears on consume unless a new instruction loads in the same cycle.
  - `out_*` hold their values while `out_valid && !out_ready`.
- `stall_cycles` increments each cycle in which state is RUN, `in_valid` is 1 and `hazard` is 1. It saturates at all-ones.
- Reset values: `out_valid`=0, `out_instr`=0, `out_type`=0, `out_dest`=0, `in_ready`=0 while `rst` is asserted, `halted`=0, `stall_cycles`=0, scoreboard cleared, state RUN.
- Reset mid-operation discards the issue register and all pending bits immediately.

## Timing
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N (one cycle).
- Back-to-back throughput is one instruction per cycle when there are no hazards and `out_ready` stays high.
- `in_ready` is combinational from `in_instr`, `out_valid`, `out_ready`, state and the scoreboard. It has no dependence on `wb_en`.
- Writeback clear at edge N unblocks a dependent instruction so that it can be accepted at edge N+1.
- HALT accepted at edge N: `halted` rises no earlier than edge N+1, and after the last pending bit clears.

## Structure
- Shared package `mips_pkg` holds:
  - type encodings R/J/HALT/I;
  - opcode constants (R-type, j, jal, halt, sw, beq, bne);
  - instruction field bit ranges.

  The decode stage uses the same constants.
- One sub-module, `reg_scoreboard`: 32-bit pending vector with set/clear ports, two read-check ports and an all-clear flag.
- The FSM, decode and issue register live in the top level.

## Test plan
- After reset, stream add r3,r1,r2 then add r5,r4,r4 with `out_ready`=1:
  - both are accepted on consecutive cycles;
  - `out_dest` = 3, then 5;
  - `stall_cycles` = 0.
- add r3,r1,r2 followed by sub r6,r3,r1, with `wb_en`/`wb_addr`=3 asserted 4 cycles later:
  - `in_ready` = 0 for exactly 4 cycles;
  - the sub is accepted on the cycle after the writeback;
  - `stall_cycles` = 4.
- lw r7 (I-type) followed by sw with rt=7: the sw stalls until writeback of 7.
- jal: `out_dest` = 31. A following add using r31 stalls.
- Writeback and a new issue to the same register (r9) in the same cycle: `pending[9]` stays 1.
- HALT with one write outstanding:
  - `in_ready` = 0 from the next cycle;
  - `halted` = 1 one cycle after the last writeback clears and `out_valid` = 0.
- Then assert `rst` mid-HALTED: all outputs return to their reset values asynchronously.
